// File: rtl/mem_access_if.sv
// Data-memory port of the M-stage load/store unit: registered request side
// from the unit, acknowledge and read data back from memory.
interface mem_access_if;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [3:0]  dBe;
    logic [31:0] dWdata;
    logic        dAck;
    logic [31:0] dRdata;

    modport master (
        output dReq, dWe, dAddr, dBe, dWdata,
        input  dAck, dRdata
    );

    modport slave (
        input  dReq, dWe, dAddr, dBe, dWdata,
        output dAck, dRdata
    );
endinterface

// File: rtl/mem_access.sv
// M-stage load/store unit: IDLE/REQ/DONE request-acknowledge sequencer with
// byte-lane formatting. Optional ack timeout is built when MEM_TIMEOUT_EN is defined.
module mem_access #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memReadM,
    input  logic                memWriteM,
    input  logic [1:0]          sizeM,
    input  logic                signedM,
    input  logic [31:0]         aluOutM,
    input  logic [31:0]         writeDataM,
    input  logic                flushM,
    mem_access_if.master        bus,
    output logic [31:0]         readDataM,
    output logic                stallM,
    output logic                addrErrM,
    output logic                busErrM
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        access, misal, valid, timeout;
    logic [1:0]  size_q, off_q;
    logic        sign_q;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_en = 4'b0001 << off;
            2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_data = {4{wd[7:0]}};
            2'b01:   lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   load_fmt = {{24{sgn & b[7]}}, b};
            2'b01:   load_fmt = {{16{sgn & h[15]}}, h};
            default: load_fmt = rdata;
        endcase
    endfunction

    assign access   = memReadM | memWriteM;
    assign misal    = ((sizeM == 2'b01) && aluOutM[0]) || (sizeM[1] && (aluOutM[1:0] != 2'b00));
    assign addrErrM = access & misal;
    assign valid    = access & ~flushM & ~misal;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] ack_cnt;

    // Counter holds 0 outside REQ, so every REQ entry starts from a clean count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_cnt <= '0;
            busErrM <= 1'b0;
        end else begin
            ack_cnt <= (state == REQ) ? ack_cnt + 1'b1 : '0;
            busErrM <= timeout;
        end
    end

    assign timeout = (state == REQ) && !bus.dAck && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
    assign busErrM = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        stallM    = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    stallM    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stallM = 1'b1;
                if (bus.dAck || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Reset releases the pipeline at once, even with a memory op presented.
        if (!rst) stallM = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bus.dReq   <= 1'b0;
            bus.dWe    <= 1'b0;
            bus.dAddr  <= '0;
            bus.dBe    <= '0;
            bus.dWdata <= '0;
            readDataM  <= '0;
            size_q     <= '0;
            off_q      <= '0;
            sign_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && valid) begin
                bus.dReq   <= 1'b1;
                bus.dWe    <= memWriteM;
                bus.dAddr  <= {aluOutM[31:2], 2'b00};
                bus.dBe    <= byte_en(sizeM, aluOutM[1:0]);
                bus.dWdata <= lane_data(sizeM, writeDataM);
                size_q     <= sizeM;
                off_q      <= aluOutM[1:0];
                sign_q     <= signedM;
            end
            // An ack in the timeout cycle wins, so the timeout path only ever zeroes the load.
            if ((state == REQ) && (bus.dAck || timeout)) begin
                bus.dReq <= 1'b0;
                if (!bus.dWe)
                    readDataM <= bus.dAck ? load_fmt(bus.dRdata, size_q, off_q, sign_q) : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a transaction-level model predicts every
// cycle's outputs and one negedge process compares them; literal checks pin the model.
module tb_mem_access;

`ifdef MEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadM, memWriteM, signedM, flushM;
    logic [1:0]  sizeM;
    logic [31:0] aluOutM, writeDataM;
    logic [31:0] readDataM;
    logic        stallM, addrErrM, busErrM;

    mem_access_if bus();

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .memReadM(memReadM), .memWriteM(memWriteM), .sizeM(sizeM), .signedM(signedM),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .flushM(flushM),
        .bus(bus),
        .readDataM(readDataM), .stallM(stallM), .addrErrM(addrErrM), .busErrM(busErrM)
    );

    always #5 clk = ~clk;

    int          total = 0, passed = 0, stall_seen = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_err, exp_buserr, exp_bus, exp_we;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] last_addr, last_wd;
    logic [3:0]  last_be;
    logic        last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int m_nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
        return (a % m_nb(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m;
        m = 4'((32'd1 << m_nb(sz)) - 1);
        return m << a[1:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = m_nb(sz);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] r);
        logic [63:0] v;
        int nb;
        nb = m_nb(sz);
        if (nb == 4) return r;
        v = 64'(r >> (8 * a[1:0])) & ((64'd1 << (8 * nb)) - 1);
        if (sgn && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // Single compare process: every cycle, outputs against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallM", {31'd0, stallM}, {31'd0, exp_stall});
            chk("dReq", {31'd0, bus.dReq}, {31'd0, exp_req});
            chk("addrErrM", {31'd0, addrErrM}, {31'd0, exp_err});
            chk("busErrM", {31'd0, busErrM}, {31'd0, exp_buserr});
            chk("readDataM", readDataM, exp_rd);
            if (stallM) stall_seen++;
            if (exp_bus) begin
                chk("dAddr", bus.dAddr, exp_addr);
                chk("dBe", {28'd0, bus.dBe}, {28'd0, exp_be});
                chk("dWe", {31'd0, bus.dWe}, {31'd0, exp_we});
                if (exp_we) chk("dWdata", bus.dWdata, exp_wd);
                last_addr = bus.dAddr;
                last_be   = bus.dBe;
                last_wd   = bus.dWdata;
                last_we   = bus.dWe;
            end
        end
    end

    // One M-stage instruction; dly = REQ cycles without ack before the acking one.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [31:0] wd, input logic fl,
                      input int dly, input logic [31:0] rdata, input logic noack);
        logic act, vld;
        int   nreq;
        act  = rd | wr;
        vld  = act && !fl && !m_misal(sz, a);
        nreq = noack ? TO : dly + 1;
        @(posedge clk); #1;
        memReadM = rd; memWriteM = wr; sizeM = sz; signedM = sgn;
        aluOutM = a; writeDataM = wd; flushM = fl;
        bus.dAck = 1'($urandom % 2); bus.dRdata = $urandom;
        stall_seen = 0;
        exp_stall = vld; exp_req = 1'b0; exp_err = act && m_misal(sz, a);
        exp_bus = 1'b0; exp_buserr = 1'b0;
        if (!vld) return;
        for (int k = 0; k < nreq; k++) begin
            @(posedge clk); #1;
            bus.dAck    = !noack && (k == dly);
            bus.dRdata  = bus.dAck ? rdata : $urandom;
            flushM      = 1'($urandom % 2);
            exp_stall   = 1'b1; exp_req = 1'b1; exp_bus = 1'b1; exp_we = wr;
            exp_addr    = a & 32'hFFFF_FFFC;
            exp_be      = m_be(sz, a);
            exp_wd      = m_wd(sz, wd);
        end
        @(posedge clk); #1;
        bus.dAck = 1'($urandom % 2); bus.dRdata = $urandom; flushM = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_bus = 1'b0; exp_buserr = noack;
        if (rd) exp_rd = noack ? 32'd0 : m_load(sz, sgn, a, rdata);
    endtask

    initial begin
        rst = 1'b0;
        memReadM = 1'b1; memWriteM = 1'b0; sizeM = 2'd2; signedM = 1'b0;
        aluOutM = 32'h100; writeDataM = '0; flushM = 1'b0;
        bus.dAck = 1'b0; bus.dRdata = '0;
        exp_stall = 0; exp_req = 0; exp_err = 0; exp_buserr = 0; exp_bus = 0; exp_we = 0;
        exp_addr = '0; exp_wd = '0; exp_rd = '0; exp_be = '0;
        #12;
        chk("rst stallM", {31'd0, stallM}, 32'd0);
        chk("rst dReq", {31'd0, bus.dReq}, 32'd0);
        chk("rst dBe", {28'd0, bus.dBe}, 32'd0);
        chk("rst dAddr", bus.dAddr, 32'd0);
        chk("rst readDataM", readDataM, 32'd0);
        chk("rst busErrM", {31'd0, busErrM}, 32'd0);
        memReadM = 1'b0;
        #10 rst = 1'b1;
        chk_en = 1'b1;

        op(1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
        chk("wordload stall cycles", stall_seen, 32'd3);
        chk("wordload dAddr", last_addr, 32'h100);
        chk("wordload dBe", {28'd0, last_be}, 32'hF);
        chk("wordload readDataM", readDataM, 32'hDEAD_BEEF);

        op(0, 1, 2'd0, 0, 32'h203, 32'h0000_00A5, 0, 0, 32'h0, 0);
        chk("bytestore dBe", {28'd0, last_be}, 32'h8);
        chk("bytestore dWdata", last_wd, 32'hA5A5_A5A5);
        chk("bytestore dWe", {31'd0, last_we}, 32'd1);

        op(1, 0, 2'd1, 1, 32'h102, 32'h0, 0, 0, 32'h8001_1234, 0);
        chk("half signed", readDataM, 32'hFFFF_8001);
        op(1, 0, 2'd1, 0, 32'h102, 32'h0, 0, 2, 32'h8001_1234, 0);
        chk("half unsigned", readDataM, 32'h0000_8001);

        op(1, 0, 2'd2, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0);
        #1;
        chk("misal addrErrM", {31'd0, addrErrM}, 32'd1);
        chk("misal dReq", {31'd0, bus.dReq}, 32'd0);
        chk("misal stallM", {31'd0, stallM}, 32'd0);
        op(1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 0, 32'h0, 0);
        #1;
        chk("flush stallM", {31'd0, stallM}, 32'd0);
        chk("flush dReq", {31'd0, bus.dReq}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        op(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 0, 32'h1234_5678, 1);
        chk("timeout stall cycles", stall_seen, 32'd5);
        chk("timeout readDataM", readDataM, 32'd0);
        op(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 3, 32'h1234_5678, 0);
        chk("late ack readDataM", readDataM, 32'h1234_5678);
`endif

        for (int n = 0; n < 400; n++) begin
            int          kind, dly;
            logic [1:0]  sz;
            logic [31:0] a;
            logic        noack;
            kind = $urandom % 4;
            sz   = 2'($urandom % 4);
            a    = $urandom;
            if ($urandom % 3 != 0) a = a & ~32'(m_nb(sz) - 1);
            dly  = $urandom % 4;
            noack = 1'b0;
`ifdef MEM_TIMEOUT_EN
            noack = ($urandom % 8 == 0);
`endif
            op(kind == 1 || kind == 3, kind == 2, sz, 1'($urandom % 2), a, $urandom,
               ($urandom % 8 == 0), dly, $urandom, noack);
        end

        // Reset while a load is outstanding in REQ.
        op(1, 0, 2'd2, 0, 32'h80, 32'h0, 0, 0, 32'hCAFE_F00D, 0);
        @(posedge clk); #1;
        memReadM = 1'b1; memWriteM = 1'b0; sizeM = 2'd2; aluOutM = 32'h84; flushM = 1'b0;
        bus.dAck = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_bus = 1'b0; exp_buserr = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b0;
        chk("pre-reset dReq", {31'd0, bus.dReq}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async rst dReq", {31'd0, bus.dReq}, 32'd0);
        chk("async rst stallM", {31'd0, stallM}, 32'd0);
        chk("async rst readDataM", readDataM, 32'd0);
        memReadM = 1'b0;
        exp_rd = '0; exp_stall = 1'b0; exp_req = 1'b0;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        op(1, 0, 2'd0, 1, 32'h81, 32'h0, 0, 0, 32'h0000_F000, 0);
        chk("post-reset byte load", readDataM, 32'hFFFF_FFF0);

        @(posedge clk); #1;
        memReadM = 1'b0; memWriteM = 1'b0; exp_stall = 1'b0; exp_err = 1'b0; exp_buserr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
